// File: rtl/ram_fifo_ctrl.sv
// FIFO sequencer for a single-port 64x8 synchronous ram with a registered head.
// Optional sticky overflow flag err_ovf when STICKY_ERR_EN is defined.
module ram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enable,
`ifdef STICKY_ERR_EN
    output logic              err_ovf,
`endif
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    typedef enum logic { IDLE, RD_WAIT } state_t;
    typedef enum logic { G_WRITE, G_READ } grant_t;

    state_t            state;
    grant_t            last_grant;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   ram_cnt;

    logic rd_valid_next;
    logic need_rd;
    logic need_wr;
    logic grant_rd;
    logic grant_wr;

    assign rd_valid_next = rd_valid && !rd_ready;
    assign need_rd = (state == IDLE) && !rd_valid_next && (ram_cnt != '0);
    assign need_wr = (state == IDLE) && wr_valid && !full;

    // Round-robin: on contention grant whichever op did not go last.
    assign grant_rd = rst_n && need_rd
                    && (!need_wr || last_grant == G_WRITE);
    assign grant_wr = rst_n && need_wr
                    && (!need_rd || last_grant == G_READ);

    assign wr_ready = rst_n && (state == IDLE) && !full
                    && (!need_rd || last_grant == G_READ);

    // The ram port is steered combinationally so a read address issued
    // in IDLE returns data during RD_WAIT, giving a 2-cycle refill.
    assign ram_write_enable = grant_wr;
    assign ram_address      = grant_wr ? wr_ptr : rd_ptr;
    assign ram_data_in      = grant_wr ? wr_data : '0;

    assign full  = (ram_cnt == DEPTH_V);
    assign count = ram_cnt + (ADDR_W + 1)'(rd_valid);
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= G_WRITE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (grant_wr) begin
                        wr_ptr     <= wr_ptr + ADDR_W'(1);
                        ram_cnt    <= ram_cnt + (ADDR_W + 1)'(1);
                        last_grant <= G_WRITE;
                    end else if (grant_rd) begin
                        state      <= RD_WAIT;
                        last_grant <= G_READ;
                    end
                end
                RD_WAIT: begin
                    rd_data  <= ram_data_out;
                    rd_valid <= 1'b1;
                    rd_ptr   <= rd_ptr + ADDR_W'(1);
                    ram_cnt  <= ram_cnt - (ADDR_W + 1)'(1);
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef STICKY_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
        end else if (wr_valid && full) begin
            err_ovf <= 1'b1;
        end
    end
`endif

endmodule
